// File: rtl/result_pkg.sv
// ============================================================================
// Module : result_pkg
// Brief  : Shared types and constants for the reaction-timer result stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package result_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_SHOW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Active-low {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [3:0] OUT_DONE = 4'd0;
    localparam logic [3:0] OUT_STAY = 4'd4;

    function automatic logic [3:0] state_onehot(input state_t s);
        return 4'b0001 << s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_decoder.sv
// ============================================================================
// Module : bcd_decoder
// Brief  : BCD digit to active-low 7-segment pattern, DP off; non-BCD blanks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_decoder
    import result_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [7:0] seg_o
);

    always_comb begin
        case (digit_i)
            4'd0:    seg_o = 8'hC0;
            4'd1:    seg_o = 8'hF9;
            4'd2:    seg_o = 8'hA4;
            4'd3:    seg_o = 8'hB0;
            4'd4:    seg_o = 8'h99;
            4'd5:    seg_o = 8'h92;
            4'd6:    seg_o = 8'h82;
            4'd7:    seg_o = 8'hF8;
            4'd8:    seg_o = 8'h80;
            4'd9:    seg_o = 8'h90;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module : tick_gen
// Brief  : Blink half-period tick and hold-expired flag, counting while en_i.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int CLK_HZ   = 50000000,
    parameter int BLINK_HZ = 2,
    parameter int HOLD_MS  = 3000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic blink_tick_o,
    output logic hold_done_o
);

    localparam longint HOLD_CYC_L = (longint'(HOLD_MS) * longint'(CLK_HZ)) / 1000;
    localparam int     HOLD_CYC   = int'(HOLD_CYC_L);
    localparam int     HOLD_TC    = (HOLD_CYC > 1) ? HOLD_CYC - 1 : 1;
    localparam int     HW         = $clog2(HOLD_TC + 1);

    localparam int     BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int     BLINK_TC   = (BLINK_HALF > 1) ? BLINK_HALF - 1 : 1;
    localparam int     BW         = $clog2(BLINK_TC + 1);

    localparam logic [HW-1:0] HOLD_TC_W  = HW'(HOLD_TC);
    localparam logic [BW-1:0] BLINK_TC_W = BW'(BLINK_TC);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [HW-1:0] hold_cnt_q,  hold_cnt_d;

    // Both counters restart from zero whenever counting is disabled
    always_comb begin
        blink_cnt_d = '0;
        hold_cnt_d  = '0;
        if (en_i) begin
            blink_cnt_d = (blink_cnt_q == BLINK_TC_W) ? '0 : blink_cnt_q + BW'(1);
            hold_cnt_d  = (hold_cnt_q == HOLD_TC_W) ? hold_cnt_q : hold_cnt_q + HW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign blink_tick_o = en_i && (blink_cnt_q == BLINK_TC_W);
    assign hold_done_o  = en_i && (hold_cnt_q == HOLD_TC_W);

endmodule

`default_nettype wire

// File: rtl/result_state.sv
// ============================================================================
// Module : result_state
// Brief  : Latches, judges and displays a reaction time; optional best-score
//          tracking when RESULT_BEST_SCORE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module result_state
    import result_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int BLINK_HZ = 2,
    parameter int HOLD_MS  = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] KEY,
    input  logic [3:0] score_a,
    input  logic [3:0] score_b,
    input  logic [3:0] score_c,
    output logic [7:0] HEX0,
    output logic [7:0] HEX1,
    output logic [7:0] HEX2,
    output logic [9:0] LEDR,
    output logic [3:0] out_state
);

    state_t     state_q, state_d;
    logic       en_q;
    bcd_t       sc_a_q, sc_b_q, sc_c_q;
    logic       invalid_q;
    logic       record_q, record_d;
    logic       phase_q, phase_d;
    logic       k0_s1_q, k0_s2_q, k0_prev_q;
    logic [7:0] hex0_q, hex1_q, hex2_q;
    logic [7:0] hex0_d, hex1_d, hex2_d;
    logic [9:0] ledr_q, ledr_d;
    logic [3:0] out_q, out_d;

    logic       en_rise, key0_fall, latch;
    logic       blink_tick, hold_done;
    logic       new_rec;
    bcd_t       idle_a, idle_b, idle_c;
    logic       idle_blank;
    bcd_t       disp_a, disp_b, disp_c;
    logic [7:0] seg0, seg1, seg2;
    logic       show;

    assign en_rise   = en && !en_q;
    assign key0_fall = k0_prev_q && !k0_s2_q;
    assign latch     = (state_q == ST_IDLE) && en_rise;

    tick_gen #(
        .CLK_HZ   (CLK_HZ),
        .BLINK_HZ (BLINK_HZ),
        .HOLD_MS  (HOLD_MS)
    ) u_tick_gen (
        .clk          (clk),
        .rst          (rst),
        .en_i         (state_q == ST_SHOW),
        .blink_tick_o (blink_tick),
        .hold_done_o  (hold_done)
    );

`ifdef RESULT_BEST_SCORE_EN
    localparam int K1_TC = 2;
    localparam int K1W   = $clog2(K1_TC + 1);

    bcd_t           best_a_q, best_b_q, best_c_q;
    logic           best_valid_q;
    logic           k1_s1_q, k1_s2_q;
    logic [K1W-1:0] k1_cnt_q;
    logic           best_clr;

    // BCD digits compare numerically when concatenated most-significant first
    assign new_rec  = !invalid_q &&
                      (!best_valid_q ||
                       ({sc_c_q, sc_b_q, sc_a_q} < {best_c_q, best_b_q, best_a_q}));
    assign best_clr = (state_q == ST_IDLE) && !k1_s2_q && (k1_cnt_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_a_q     <= '0;
            best_b_q     <= '0;
            best_c_q     <= '0;
            best_valid_q <= 1'b0;
            k1_s1_q      <= 1'b0;
            k1_s2_q      <= 1'b0;
            k1_cnt_q     <= '0;
        end else begin
            k1_s1_q <= KEY[1];
            k1_s2_q <= k1_s1_q;
            if ((state_q == ST_IDLE) && !k1_s2_q) begin
                if (k1_cnt_q != K1W'(K1_TC))
                    k1_cnt_q <= k1_cnt_q + K1W'(1);
            end else begin
                k1_cnt_q <= '0;
            end
            if ((state_q == ST_CHECK) && (state_d == ST_SHOW) && new_rec) begin
                best_a_q     <= sc_a_q;
                best_b_q     <= sc_b_q;
                best_c_q     <= sc_c_q;
                best_valid_q <= 1'b1;
            end else if (best_clr) begin
                best_valid_q <= 1'b0;
            end
        end
    end

    assign idle_a     = best_a_q;
    assign idle_b     = best_b_q;
    assign idle_c     = best_c_q;
    assign idle_blank = !best_valid_q;
`else
    logic unused_key1;
    assign unused_key1 = KEY[1];
    assign new_rec     = 1'b0;
    assign idle_a      = '0;
    assign idle_b      = '0;
    assign idle_c      = '0;
    assign idle_blank  = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Loss of en wins over hold expiry and skip
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en_rise) state_d = ST_CHECK;
            ST_CHECK: state_d = en ? ST_SHOW : ST_IDLE;
            ST_SHOW: begin
                if (!en)
                    state_d = ST_IDLE;
                else if (hold_done || key0_fall)
                    state_d = ST_DONE;
            end
            ST_DONE:  if (!en) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        record_d = record_q;
        if (state_q == ST_CHECK)
            record_d = new_rec;
        if (state_d == ST_IDLE)
            record_d = 1'b0;
        phase_d = ((state_q == ST_SHOW) && (state_d == ST_SHOW)) ? (phase_q ^ blink_tick) : 1'b0;
    end

    // Outputs are registered from next-state values so they track state_d
    always_comb begin
        show   = (state_d == ST_SHOW) || (state_d == ST_DONE);
        disp_a = show ? sc_a_q : idle_a;
        disp_b = show ? sc_b_q : idle_b;
        disp_c = show ? sc_c_q : idle_c;
    end

    bcd_decoder u_dec0 (.digit_i(disp_a), .seg_o(seg0));
    bcd_decoder u_dec1 (.digit_i(disp_b), .seg_o(seg1));
    bcd_decoder u_dec2 (.digit_i(disp_c), .seg_o(seg2));

    always_comb begin
        hex0_d = seg0;
        hex1_d = seg1;
        hex2_d = seg2;
        if (!show) begin
            if (idle_blank) begin
                hex0_d = SEG_BLANK;
                hex1_d = SEG_BLANK;
                hex2_d = SEG_BLANK;
            end
        end else if (invalid_q) begin
            hex0_d = SEG_DASH;
            hex1_d = SEG_DASH;
            hex2_d = SEG_DASH;
        end else if ((state_d == ST_SHOW) && record_d && phase_d) begin
            hex0_d = SEG_BLANK;
            hex1_d = SEG_BLANK;
            hex2_d = SEG_BLANK;
        end
        ledr_d = {record_d && (state_d == ST_SHOW), 5'b00000, state_onehot(state_d)};
        out_d  = (state_d == ST_DONE) ? OUT_DONE : OUT_STAY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= 1'b1;
            sc_a_q    <= '0;
            sc_b_q    <= '0;
            sc_c_q    <= '0;
            invalid_q <= 1'b0;
            record_q  <= 1'b0;
            phase_q   <= 1'b0;
            k0_s1_q   <= 1'b0;
            k0_s2_q   <= 1'b0;
            k0_prev_q <= 1'b0;
            hex0_q    <= SEG_BLANK;
            hex1_q    <= SEG_BLANK;
            hex2_q    <= SEG_BLANK;
            ledr_q    <= '0;
            out_q     <= OUT_STAY;
        end else begin
            en_q      <= en;
            k0_s1_q   <= KEY[0];
            k0_s2_q   <= k0_s1_q;
            k0_prev_q <= k0_s2_q;
            if (latch) begin
                sc_a_q    <= score_a;
                sc_b_q    <= score_b;
                sc_c_q    <= score_c;
                invalid_q <= (score_a > 4'd9) || (score_b > 4'd9) || (score_c > 4'd9);
            end
            record_q <= record_d;
            phase_q  <= phase_d;
            hex0_q   <= hex0_d;
            hex1_q   <= hex1_d;
            hex2_q   <= hex2_d;
            ledr_q   <= ledr_d;
            out_q    <= out_d;
        end
    end

    assign HEX0      = hex0_q;
    assign HEX1      = hex1_q;
    assign HEX2      = hex2_q;
    assign LEDR      = ledr_q;
    assign out_state = out_q;

endmodule

`default_nettype wire

// File: tb/tb_result_state.sv
// ============================================================================
// Module : tb_result_state
// Brief  : Directed-vector bench for result_state (sim clock 1 kHz scale).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_result_state;

`ifdef RESULT_BEST_SCORE_EN
    localparam bit BEST = 1'b1;
`else
    localparam bit BEST = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] KEY;
    logic [3:0] score_a, score_b, score_c;
    logic [7:0] HEX0, HEX1, HEX2;
    logic [9:0] LEDR;
    logic [3:0] out_state;

    int n_tests = 0;
    int n_fail  = 0;

    result_state #(
        .CLK_HZ   (1000),
        .BLINK_HZ (50),
        .HOLD_MS  (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .KEY       (KEY),
        .score_a   (score_a),
        .score_b   (score_b),
        .score_c   (score_c),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .LEDR      (LEDR),
        .out_state (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_score(input logic [3:0] c, input logic [3:0] b, input logic [3:0] a);
        score_c = c;
        score_b = b;
        score_a = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        KEY = 2'b11;
        set_score(4'd0, 4'd0, 4'd0);
        #22;
        check("rst_hex0", HEX0, 8'hFF);
        check("rst_ledr", LEDR, 10'h000);
        check("rst_out",  out_state, 4'd4);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        check("idle_ledr", LEDR, 10'h001);
        check("idle_hex2", HEX2, 8'hFF);

        // 142 ms, best empty
        set_score(4'd1, 4'd4, 4'd2);
        en = 1'b1;
        step(1);
        check("a_check_ledr", LEDR, 10'h002);
        check("a_check_hex0", HEX0, 8'hFF);
        step(1);
        check("a_show_hex0", HEX0, 8'hA4);
        check("a_show_hex1", HEX1, 8'h99);
        check("a_show_hex2", HEX2, 8'hF9);
        check("a_show_ledr", LEDR, BEST ? 10'h204 : 10'h004);
        step(9);
        check("a_blink_on_end", HEX0, 8'hA4);
        step(1);
        check("a_blink_off", HEX0, BEST ? 8'hFF : 8'hA4);
        check("a_blink_off1", HEX1, BEST ? 8'hFF : 8'h99);
        step(10);
        check("a_blink_on2", HEX0, 8'hA4);
        step(79);
        check("a_hold_last", LEDR[3:0], 4'h4);
        check("a_hold_out", out_state, 4'd4);
        step(1);
        check("a_done_ledr", LEDR, 10'h008);
        check("a_done_out", out_state, 4'd0);
        check("a_done_hex0", HEX0, 8'hA4);
        en = 1'b0;
        step(1);
        check("a_idle_ledr", LEDR, 10'h001);
        check("a_idle_hex0", HEX0, BEST ? 8'hA4 : 8'hFF);
        check("a_idle_out", out_state, 4'd4);

        // 299 ms: never a record
        set_score(4'd2, 4'd9, 4'd9);
        en = 1'b1;
        step(2);
        check("b_show_hex0", HEX0, 8'h90);
        check("b_show_hex2", HEX2, 8'hA4);
        check("b_show_ledr", LEDR, 10'h004);
        step(15);
        check("b_steady_hex0", HEX0, 8'h90);
        en = 1'b0;
        step(1);
        check("b_abort_ledr", LEDR, 10'h001);
        check("b_best_hex0", HEX0, BEST ? 8'hA4 : 8'hFF);
        check("b_best_hex2", HEX2, BEST ? 8'hF9 : 8'hFF);

        // invalid digit
        set_score(4'd1, 4'd4, 4'hC);
        en = 1'b1;
        step(2);
        check("c_dash_hex0", HEX0, 8'hBF);
        check("c_dash_hex2", HEX2, 8'hBF);
        check("c_dash_ledr", LEDR, 10'h004);
        en = 1'b0;
        step(1);
        check("c_best_hex0", HEX0, BEST ? 8'hA4 : 8'hFF);

        // KEY[0] skip 30 cycles into SHOW
        set_score(4'd3, 4'd5, 4'd0);
        en = 1'b1;
        step(2);
        check("d_show_hex0", HEX0, 8'hC0);
        step(29);
        KEY[0] = 1'b0;
        step(2);
        check("d_sync_show", LEDR[3:0], 4'h4);
        step(1);
        check("d_skip_ledr", LEDR, 10'h008);
        check("d_skip_out", out_state, 4'd0);
        KEY[0] = 1'b1;
        en = 1'b0;
        step(1);
        check("d_idle_ledr", LEDR, 10'h001);
        step(3);

        // en drop 20 cycles into SHOW
        set_score(4'd1, 4'd4, 4'd2);
        en = 1'b1;
        step(2);
        check("e_show_ledr", LEDR, 10'h004);
        step(19);
        en = 1'b0;
        step(1);
        check("e_abort_ledr", LEDR, 10'h001);
        check("e_abort_out", out_state, 4'd4);
        check("e_abort_hex0", HEX0, BEST ? 8'hA4 : 8'hFF);

        // reset mid-SHOW with en held high
        set_score(4'd1, 4'd2, 4'd0);
        en = 1'b1;
        step(2);
        check("f_show_ledr", LEDR, BEST ? 10'h204 : 10'h004);
        step(5);
        rst = 1'b1;
        #2;
        check("f_rst_ledr", LEDR, 10'h000);
        check("f_rst_hex0", HEX0, 8'hFF);
        check("f_rst_out",  out_state, 4'd4);
        #2;
        rst = 1'b0;
        step(5);
        check("f_no_restart", LEDR, 10'h001);
        check("f_idle_blank", HEX0, 8'hFF);
        en = 1'b0;
        step(1);
        en = 1'b1;
        step(2);
        check("f_restart_ledr", LEDR[3:0], 4'h4);
        check("f_restart_hex0", HEX0, 8'hC0);
        step(10);
        check("f_blink", HEX0, BEST ? 8'hFF : 8'hC0);
        en = 1'b0;
        step(1);
        check("f_best_hex0", HEX0, BEST ? 8'hC0 : 8'hFF);
        check("f_best_hex1", HEX1, BEST ? 8'hA4 : 8'hFF);

        // KEY[1] clear of best
        KEY[1] = 1'b0;
        step(5);
        KEY[1] = 1'b1;
        step(1);
        check("g_clear_hex0", HEX0, 8'hFF);
        check("g_clear_hex1", HEX1, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
